phase_scheduler: RTL
====================

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 25000000: prescaler period in clk cycles per countdown tick.
REQ-002 Parameter PHASE_SEC, default 9: countdown load value per phase, range 1..15.
REQ-003 clk  input  1  25 MHz system clock; single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btnU, btnD, btnL, btnR, btnC  input  1 each  raw push buttons, level, active-high.
REQ-006 cur_phase  output  3  current phase, 0..4.
REQ-007 seven_num  output  4  remaining countdown value.
REQ-008 minus_1  output  1  one-cycle countdown tick pulse.
REQ-009 round_done  output  1  one-cycle pulse on completing phase 4.
REQ-010 win_cnt  output  4  completed-round count, saturating.

Function
REQ-011 Each button SHALL be registered into btn_q, then into btn_prev; press = btn_q & ~btn_prev.
REQ-012 A raw input high before edge k SHALL produce its press decision at edge k+1, with the state update visible after edge k+1.
REQ-013 The prescaler SHALL count 0..CLK_HZ-1 and wrap. minus_1 SHALL be registered high for exactly the one cycle following the wrap.
REQ-014 Expected button per phase: 0->btnD, 1->btnL, 2->btnC, 3->btnU, 4->btnR.
REQ-015 A correct press is exactly one press asserted, equal to the expected button. On a correct press the block SHALL:
- advance cur_phase 0->1->2->3->4->0;
- reload seven_num to PHASE_SEC;
- clear the prescaler.
REQ-016 A correct press in phase 4 SHALL pulse round_done for 1 cycle and increment win_cnt, saturating at 15.
REQ-017 A wrong press is any press that is not a correct press, including two or more simultaneous presses. It is handled per REQ-025/026.
REQ-018 On minus_1 with seven_num>0, seven_num SHALL decrement by 1.
REQ-019 On minus_1 with seven_num==0 (timeout), the block SHALL set cur_phase to 0, reload seven_num to PHASE_SEC, and leave win_cnt unchanged.
REQ-020 Priority within one cycle: correct press > timeout/decrement > wrong-press penalty.
REQ-021 If cur_phase holds 5..7, the block SHALL force cur_phase to 0 and reload seven_num on the next edge.
REQ-022 Button holds SHALL generate only one press; release and re-press are required.

Reset
REQ-023 While rst=1, the block SHALL asynchronously force:
- cur_phase=0, seven_num=PHASE_SEC;
- minus_1=0, round_done=0, win_cnt=0;
- prescaler=0, all button registers=0.
REQ-024 Reset mid-countdown or mid-round SHALL discard all progress. Counting SHALL resume from prescaler=0 on the first edge after rst falls.

Configuration
REQ-025 With macro PHASE_PENALTY_EN defined, a wrong press SHALL subtract 2 from seven_num, saturating at 0. A timeout SHALL then occur on the next minus_1, per REQ-019.
REQ-026 Without PHASE_PENALTY_EN, wrong presses SHALL have no effect on any state.

Verification
All scenarios use CLK_HZ=4 and PHASE_SEC=3.
REQ-027 Reset, then run 8 cycles -> minus_1 pulses at cycles 4 and 8; seven_num goes 3->2->1.
REQ-028 Press D, L, C, U, R in order, each 1 cycle high, spaced 2 cycles -> cur_phase 1,2,3,4,0; round_done pulses once; win_cnt=1; seven_num=3 after each press.
REQ-029 Idle in phase 2 for 16 cycles -> seven_num 3,2,1,0, then timeout -> cur_phase=0, seven_num=3.
REQ-030 In phase 0, btnD and btnL high in the same cycle -> cur_phase stays 0.
- With PHASE_PENALTY_EN: seven_num 3->1.
- Without PHASE_PENALTY_EN: seven_num stays 3.
REQ-031 Hold btnD for 10 cycles -> only one advance, cur_phase=1. Correct press in the same cycle as minus_1 -> phase advances and seven_num=3, not 2.
REQ-032 Assert rst mid-phase 3 with win_cnt=5 -> all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/phase_scheduler_if.sv
// Purpose: button inputs and phase/countdown status of the phase scheduler.
// Latency: none; this is a plain bundle of wires.
// Backpressure: none; the buttons are levels and the status outputs are sampled freely.
interface phase_scheduler_if;
    // raw push buttons, level, active-high
    logic       btnU;
    logic       btnD;
    logic       btnL;
    logic       btnR;
    logic       btnC;
    // scheduler status
    logic [2:0] cur_phase;
    logic [3:0] seven_num;
    logic       minus_1;
    logic       round_done;
    logic [3:0] win_cnt;

    // stimulus side: drives the buttons and observes the status
    modport master (
        output btnU, btnD, btnL, btnR, btnC,
        input  cur_phase, seven_num, minus_1, round_done, win_cnt
    );

    // scheduler side: receives the buttons and drives the status
    modport slave (
        input  btnU, btnD, btnL, btnR, btnC,
        output cur_phase, seven_num, minus_1, round_done, win_cnt
    );
endinterface

// File: rtl/phase_scheduler.sv
// Purpose: five-phase button sequence game with a per-phase countdown; PHASE_PENALTY_EN enables the wrong-press penalty.
// Latency: a raw button seen at edge k is acted on at edge k+1; minus_1 follows a prescaler wrap by one cycle.
// Backpressure: none; held buttons produce one press, and presses that arrive during a wrong phase are dropped.
module phase_scheduler #(
    parameter int CLK_HZ    = 25000000,
    parameter int PHASE_SEC = 9
) (
    input  logic              clk,
    input  logic              rst,
    phase_scheduler_if.slave  sched
);
    localparam int             PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0]     SEC_LOAD  = 4'(PHASE_SEC);
    localparam logic [3:0]     WIN_MAX   = 4'd15;

    // phase encoding; each name gives the button that phase expects
    localparam logic [2:0] PH_D = 3'd0;
    localparam logic [2:0] PH_L = 3'd1;
    localparam logic [2:0] PH_C = 3'd2;
    localparam logic [2:0] PH_U = 3'd3;
    localparam logic [2:0] PH_R = 3'd4;

    // button vector bit masks, order {U, D, L, R, C}
    localparam logic [4:0] B_U = 5'b10000;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_L = 5'b00100;
    localparam logic [4:0] B_R = 5'b00010;
    localparam logic [4:0] B_C = 5'b00001;

    logic [4:0]    btn_raw;
    logic [4:0]    btn_q;
    logic [4:0]    btn_prev;
    logic [4:0]    press;
    logic [4:0]    expect_mask;
    logic          correct;
    logic [PW-1:0] presc;
    logic [2:0]    cur_phase;
    logic [3:0]    seven_num;
    logic          minus_1;
    logic          round_done;
    logic [3:0]    win_cnt;

    assign btn_raw = {sched.btnU, sched.btnD, sched.btnL, sched.btnR, sched.btnC};

    // Two-stage button capture; the rising edge between the stages is one press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q    <= '0;
            btn_prev <= '0;
        end else begin
            btn_q    <= btn_raw;
            btn_prev <= btn_q;
        end
    end

    assign press = btn_q & ~btn_prev;

    // Expected button for the current phase; invalid phases expect nothing.
    always_comb begin
        expect_mask = '0;
        case (cur_phase)
            PH_D:    expect_mask = B_D;
            PH_L:    expect_mask = B_L;
            PH_C:    expect_mask = B_C;
            PH_U:    expect_mask = B_U;
            PH_R:    expect_mask = B_R;
            default: expect_mask = '0;
        endcase
    end

    // A single press of exactly the expected button; multi-presses never match a one-hot mask.
    assign correct = (press != '0) && (press == expect_mask);

    // Prescaler: wraps every CLK_HZ cycles, restarts on a correct press; minus_1 is the registered wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            minus_1 <= 1'b0;
        end else begin
            minus_1 <= (presc == PRESC_MAX) && !correct;
            if (correct || presc == PRESC_MAX) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Phase / countdown / score: correct press beats tick handling, which beats the penalty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_phase  <= PH_D;
            seven_num  <= SEC_LOAD;
            round_done <= 1'b0;
            win_cnt    <= '0;
        end else begin
            round_done <= correct && (cur_phase == PH_R);
            if (cur_phase > PH_R) begin
                cur_phase <= PH_D;
                seven_num <= SEC_LOAD;
            end else if (correct) begin
                cur_phase <= (cur_phase == PH_R) ? PH_D : cur_phase + 3'd1;
                seven_num <= SEC_LOAD;
                if (cur_phase == PH_R && win_cnt != WIN_MAX) begin
                    win_cnt <= win_cnt + 4'd1;
                end
            end else if (minus_1) begin
                if (seven_num == 4'd0) begin
                    cur_phase <= PH_D;
                    seven_num <= SEC_LOAD;
                end else begin
                    seven_num <= seven_num - 4'd1;
                end
            end
`ifdef PHASE_PENALTY_EN
            else if (press != '0) begin
                seven_num <= (seven_num >= 4'd2) ? seven_num - 4'd2 : 4'd0;
            end
`endif
        end
    end

    assign sched.cur_phase  = cur_phase;
    assign sched.seven_num  = seven_num;
    assign sched.minus_1    = minus_1;
    assign sched.round_done = round_done;
    assign sched.win_cnt    = win_cnt;
endmodule
